altera_eth_pause_frame_gen: RTL and testbench

- Consumes the 2-bit pause control request stream that the FIFO pause-control adapter produces (bit1 = XOFF request, bit0 = XON request).
- Builds IEEE 802.3x PAUSE MAC-control frames and streams them byte-wide over Avalon-ST to the MAC TX control-frame port.
- Tracks pause state and periodically refreshes XOFF while the request persists, so the link partner's quanta timer never expires mid-congestion.
- Sits between the RX FIFO pause adapter and the MAC transmit path.

---
 rtl/altera_eth_pause_frame_gen.sv | 263 ++++++++++++++++++++++++++
 tb/tb_altera_eth_pause_frame_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altera_eth_pause_frame_gen.sv
// IEEE 802.3x PAUSE frame generator.
// Turns the XOFF/XON request levels from the RX FIFO pause adapter into
// 60-byte MAC-control frames on a byte-wide Avalon-ST source, tracks the
// local pause state and re-sends XOFF before the peer's quanta runs out.
module altera_eth_pause_frame_gen #(
  parameter logic [47:0] MAC_ADDR       = 48'h000000000000,
  parameter logic [15:0] PAUSE_QUANTA   = 16'hFFFF,
  parameter logic [23:0] REFRESH_CYCLES = 24'd2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] pause_ctrl_sink_data,
  output logic [7:0] src_data,
  output logic       src_valid,
  input  logic       src_ready,
  output logic       src_startofpacket,
  output logic       src_endofpacket,
  output logic       pause_active,
  output logic       frame_sent
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'd59;

  // Frame content for a given byte index; bytes past the header are padding.
  function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic is_xoff);
    logic [7:0] b;
    case (idx)
      6'd0:    b = 8'h01;
      6'd1:    b = 8'h80;
      6'd2:    b = 8'hC2;
      6'd3:    b = 8'h00;
      6'd4:    b = 8'h00;
      6'd5:    b = 8'h01;
      6'd6:    b = MAC_ADDR[47:40];
      6'd7:    b = MAC_ADDR[39:32];
      6'd8:    b = MAC_ADDR[31:24];
      6'd9:    b = MAC_ADDR[23:16];
      6'd10:   b = MAC_ADDR[15:8];
      6'd11:   b = MAC_ADDR[7:0];
      6'd12:   b = 8'h88;
      6'd13:   b = 8'h08;
      6'd14:   b = 8'h00;
      6'd15:   b = 8'h01;
      6'd16:   b = is_xoff ? PAUSE_QUANTA[15:8] : 8'h00;
      6'd17:   b = is_xoff ? PAUSE_QUANTA[7:0]  : 8'h00;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Input stage
  logic [1:0]  req_q1_r;
  logic [1:0]  req_q2_r;
  logic [1:0]  rise_s;
  logic        xoff_ev_r;
  logic        xon_ev_r;

  // Pending requests and pause state
  logic        xoff_pend_r;
  logic        xon_pend_r;
  logic        xoff_pend_nxt_s;
  logic        xon_pend_nxt_s;
  logic        xon_ok_s;
  logic        pause_active_r;
  logic [23:0] timer_r;
  logic        timer_exp_s;

  // Frame FSM and registered source outputs
  state_t      state_r;
  state_t      state_nxt_s;
  logic        type_xoff_r;
  logic        type_xoff_nxt_s;
  logic [5:0]  idx_r;
  logic [5:0]  idx_nxt_s;
  logic [7:0]  data_r;
  logic [7:0]  data_nxt_s;
  logic        valid_r;
  logic        valid_nxt_s;
  logic        sop_r;
  logic        sop_nxt_s;
  logic        eop_r;
  logic        eop_nxt_s;
  logic        frame_sent_r;
  logic        frame_sent_nxt_s;
  logic        take_xoff_s;
  logic        take_xon_s;
  logic        eop_xfer_s;
  logic        xfer_s;

  assign rise_s      = req_q1_r & ~req_q2_r;
  assign xfer_s      = valid_r & src_ready;
  // Refresh fires on the 1-to-0 step of the timer, only while XOFF is still requested.
  assign timer_exp_s = (state_r == ST_IDLE) && (timer_r == 24'd1) && req_q1_r[1];
  // XON is only meaningful if the peer is (or is about to be) paused.
  assign xon_ok_s    = pause_active_r | xoff_pend_r | ((state_r == ST_SEND) & type_xoff_r);

  // Register the request levels twice and register the derived events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q1_r  <= 2'b00;
      req_q2_r  <= 2'b00;
      xoff_ev_r <= 1'b0;
      xon_ev_r  <= 1'b0;
    end else begin
      req_q1_r  <= pause_ctrl_sink_data;
      req_q2_r  <= req_q1_r;
      xoff_ev_r <= rise_s[1] | timer_exp_s;
      xon_ev_r  <= rise_s[0];
    end
  end

  // Pending-flag update: newest event wins, XOFF beats XON in the same cycle.
  always_comb begin
    xoff_pend_nxt_s = xoff_pend_r;
    xon_pend_nxt_s  = xon_pend_r;
    if (xoff_ev_r) begin
      xoff_pend_nxt_s = 1'b1;
      xon_pend_nxt_s  = 1'b0;
    end else if (xon_ev_r && xon_ok_s) begin
      xon_pend_nxt_s  = 1'b1;
      xoff_pend_nxt_s = 1'b0;
    end else begin
      if (take_xoff_s) begin
        xoff_pend_nxt_s = 1'b0;
      end else begin
        xoff_pend_nxt_s = xoff_pend_r;
      end
      if (take_xon_s) begin
        xon_pend_nxt_s = 1'b0;
      end else begin
        xon_pend_nxt_s = xon_pend_r;
      end
    end
  end

  // Pending flags register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xoff_pend_r <= 1'b0;
      xon_pend_r  <= 1'b0;
    end else begin
      xoff_pend_r <= xoff_pend_nxt_s;
      xon_pend_r  <= xon_pend_nxt_s;
    end
  end

  // Pause state and XOFF refresh timer; the timer only runs while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pause_active_r <= 1'b0;
      timer_r        <= 24'd0;
    end else if (eop_xfer_s) begin
      if (type_xoff_r) begin
        pause_active_r <= 1'b1;
        timer_r        <= REFRESH_CYCLES;
      end else begin
        pause_active_r <= 1'b0;
        timer_r        <= 24'd0;
      end
    end else if ((state_r == ST_IDLE) && (timer_r != 24'd0)) begin
      timer_r <= timer_r - 24'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Frame FSM next state and next registered outputs.
  always_comb begin
    state_nxt_s      = state_r;
    type_xoff_nxt_s  = type_xoff_r;
    idx_nxt_s        = idx_r;
    data_nxt_s       = data_r;
    valid_nxt_s      = valid_r;
    sop_nxt_s        = sop_r;
    eop_nxt_s        = eop_r;
    frame_sent_nxt_s = 1'b0;
    take_xoff_s      = 1'b0;
    take_xon_s       = 1'b0;
    eop_xfer_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xoff_pend_r || xon_pend_r) begin
          take_xoff_s     = xoff_pend_r;
          take_xon_s      = ~xoff_pend_r;
          type_xoff_nxt_s = xoff_pend_r;
          state_nxt_s     = ST_SEND;
          idx_nxt_s       = 6'd0;
          data_nxt_s      = frame_byte(6'd0, xoff_pend_r);
          valid_nxt_s     = 1'b1;
          sop_nxt_s       = 1'b1;
          eop_nxt_s       = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          if (idx_r == LAST_IDX) begin
            eop_xfer_s       = 1'b1;
            frame_sent_nxt_s = 1'b1;
            state_nxt_s      = ST_IDLE;
            idx_nxt_s        = 6'd0;
            data_nxt_s       = 8'h00;
            valid_nxt_s      = 1'b0;
            sop_nxt_s        = 1'b0;
            eop_nxt_s        = 1'b0;
          end else begin
            idx_nxt_s  = idx_r + 6'd1;
            data_nxt_s = frame_byte(idx_r + 6'd1, type_xoff_r);
            sop_nxt_s  = 1'b0;
            eop_nxt_s  = (idx_r == (LAST_IDX - 6'd1));
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = 6'd0;
        data_nxt_s  = 8'h00;
        valid_nxt_s = 1'b0;
        sop_nxt_s   = 1'b0;
        eop_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state and source output registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      type_xoff_r  <= 1'b0;
      idx_r        <= 6'd0;
      data_r       <= 8'h00;
      valid_r      <= 1'b0;
      sop_r        <= 1'b0;
      eop_r        <= 1'b0;
      frame_sent_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      type_xoff_r  <= type_xoff_nxt_s;
      idx_r        <= idx_nxt_s;
      data_r       <= data_nxt_s;
      valid_r      <= valid_nxt_s;
      sop_r        <= sop_nxt_s;
      eop_r        <= eop_nxt_s;
      frame_sent_r <= frame_sent_nxt_s;
    end
  end

  assign src_data          = data_r;
  assign src_valid         = valid_r;
  assign src_startofpacket = sop_r;
  assign src_endofpacket   = eop_r;
  assign pause_active      = pause_active_r;
  assign frame_sent        = frame_sent_r;

endmodule

// File: tb/tb_altera_eth_pause_frame_gen.sv
// Self-checking bench for altera_eth_pause_frame_gen: a scoreboard of
// expected frame types, a byte-template model of the PAUSE frame and a
// beat monitor, driven by directed and randomized request patterns.
module tb_altera_eth_pause_frame_gen;

  localparam logic [47:0] MAC     = 48'h001122334455;
  localparam logic [15:0] QUANTA  = 16'h1234;
  localparam logic [23:0] REFRESH = 24'd100;
  // Expiry behaves like a request sampled one edge earlier, then the 3-edge request latency.
  localparam int REFRESH_GAP = 100 + 3;
  // eop edge -> one idle cycle -> sop transfer.
  localparam int BACK2BACK_GAP = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] pause_ctrl_sink_data = 2'b00;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready = 1'b1;
  logic       src_startofpacket;
  logic       src_endofpacket;
  logic       pause_active;
  logic       frame_sent;

  altera_eth_pause_frame_gen #(
    .MAC_ADDR      (MAC),
    .PAUSE_QUANTA  (QUANTA),
    .REFRESH_CYCLES(REFRESH)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .pause_ctrl_sink_data(pause_ctrl_sink_data),
    .src_data            (src_data),
    .src_valid           (src_valid),
    .src_ready           (src_ready),
    .src_startofpacket   (src_startofpacket),
    .src_endofpacket     (src_endofpacket),
    .pause_active        (pause_active),
    .frame_sent          (frame_sent)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit bp_en = 1'b0;

  // Scoreboard: expected frame types in order (1 = XOFF, 0 = XON).
  bit exp_q[$];
  // Monitor / model state
  bit in_frame = 1'b0;
  bit cur_xoff = 1'b0;
  int b = 0;
  bit model_pa = 1'b0;
  bit eop_prev = 1'b0;
  bit hold = 1'b0;
  logic [9:0] held = 10'd0;
  int last_eop_cyc = 0;
  int last_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference PAUSE frame byte from the frame layout.
  function automatic logic [7:0] exp_byte(input int i, input bit xoff);
    logic [47:0] mac;
    logic [15:0] q;
    logic [7:0]  da [0:5];
    mac = MAC;
    q   = xoff ? QUANTA : 16'h0000;
    da[0] = 8'h01; da[1] = 8'h80; da[2] = 8'hC2;
    da[3] = 8'h00; da[4] = 8'h00; da[5] = 8'h01;
    if (i < 6)        return da[i];
    else if (i < 12)  return mac[8*(11-i) +: 8];
    else if (i == 12) return 8'h88;
    else if (i == 13) return 8'h08;
    else if (i == 14) return 8'h00;
    else if (i == 15) return 8'h01;
    else if (i == 16) return q[15:8];
    else if (i == 17) return q[7:0];
    else              return 8'h00;
  endfunction

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready driver: random backpressure when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    src_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Beat monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      in_frame = 1'b0;
      b        = 0;
      model_pa = 1'b0;
      eop_prev = 1'b0;
      hold     = 1'b0;
    end else begin
      if (frame_sent || eop_prev) chk("frame_sent", 32'(frame_sent), 32'(eop_prev));
      if (hold) begin
        chk("hold_valid", 32'(src_valid), 32'd1);
        chk("hold_beat", 32'({src_data, src_startofpacket, src_endofpacket}), 32'(held));
      end
      hold     = src_valid && !src_ready;
      held     = {src_data, src_startofpacket, src_endofpacket};
      eop_prev = 1'b0;
      if (src_valid && src_ready) begin
        if (!in_frame) begin
          chk("sop_at_frame_start", 32'(src_startofpacket), 32'd1);
          chk("expected_frame_queued", 32'(exp_q.size() > 0), 32'd1);
          cur_xoff = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
          in_frame = 1'b1;
          b        = 0;
          last_gap = cyc + 1 - last_eop_cyc;
        end
        chk("data", 32'(src_data), 32'(exp_byte(b, cur_xoff)));
        chk("sop", 32'(src_startofpacket), 32'(b == 0));
        chk("eop", 32'(src_endofpacket), 32'(b == 59));
        b++;
        if (src_endofpacket) begin
          chk("beats", 32'(b), 32'd60);
          in_frame     = 1'b0;
          model_pa     = cur_xoff;
          eop_prev     = 1'b1;
          last_eop_cyc = cyc + 1;
        end
      end
    end
  end

  // Raise the given request bits for three cycles, then drop them.
  task automatic pulse(input logic [1:0] bits);
    @(posedge clk);
    #1 pause_ctrl_sink_data = bits;
    repeat (3) @(posedge clk);
    #1 pause_ctrl_sink_data = 2'b00;
  endtask

  // Wait (bounded) until every expected frame has been seen and the source is idle.
  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !in_frame && !src_valid) break;
    end
    chk("idle_reached", 32'(exp_q.size() == 0 && !in_frame && !src_valid), 32'd1);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    int k;
    int sel;

    // Reset holds everything quiet while inputs toggle.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 pause_ctrl_sink_data = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("reset_outputs", 32'({src_valid, src_startofpacket, src_endofpacket,
                               pause_active, frame_sent, src_data}), 32'd0);
    end
    @(posedge clk);
    #1 pause_ctrl_sink_data = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_after_reset", 32'(src_valid), 32'd0);
    end

    // Single XOFF with latency measurement.
    @(posedge clk);
    #1;
    exp_q.push_back(1'b1);
    pause_ctrl_sink_data = 2'b10;
    for (k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (src_valid) break;
    end
    chk("xoff_latency", 32'(k), 32'd4);
    pause_ctrl_sink_data = 2'b00;
    wait_idle();
    chk("pause_after_xoff", 32'(pause_active), 32'(model_pa));
    chk("pause_set", 32'(pause_active), 32'd1);

    // XON after XOFF, then a second XON that must be ignored.
    exp_q.push_back(1'b0);
    pulse(2'b01);
    wait_idle();
    chk("pause_clear", 32'(pause_active), 32'd0);
    pulse(2'b01);
    repeat (40) @(posedge clk);
    chk("ignored_xon", 32'(in_frame || src_valid), 32'd0);

    // XOFF under random backpressure.
    bp_en = 1'b1;
    exp_q.push_back(1'b1);
    pulse(2'b10);
    wait_idle();
    bp_en = 1'b0;
    chk("pause_after_bp_xoff", 32'(pause_active), 32'd1);

    // Randomized request mix.
    for (int it = 0; it < 12; it++) begin
      bp_en = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        exp_q.push_back(1'b1);
        pulse(2'b10);
      end else if (sel == 1) begin
        if (model_pa) exp_q.push_back(1'b0);
        pulse(2'b01);
      end else begin
        exp_q.push_back(1'b1);
        pulse(2'b11);
      end
      wait_idle();
      chk("pause_random", 32'(pause_active), 32'(model_pa));
    end
    bp_en = 1'b0;
    repeat (3) @(posedge clk);

    // Refresh while XOFF is held, then none after it drops.
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    @(posedge clk);
    #1 pause_ctrl_sink_data = 2'b10;
    wait_idle();
    #1 pause_ctrl_sink_data = 2'b00;
    chk("refresh_gap", 32'(last_gap), 32'(REFRESH_GAP));
    repeat (300) @(posedge clk);
    chk("no_refresh_after_drop", 32'(in_frame || src_valid || exp_q.size() != 0), 32'd0);
    chk("pause_held", 32'(pause_active), 32'd1);

    // Simultaneous XOFF+XON rise while paused: one XOFF only.
    exp_q.push_back(1'b1);
    pulse(2'b11);
    wait_idle();
    chk("pause_after_collision", 32'(pause_active), 32'd1);

    // XON arriving mid-XOFF frame queues behind it.
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1 pause_ctrl_sink_data = 2'b10;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (b >= 20 && in_frame) break;
    end
    #1 pause_ctrl_sink_data = 2'b11;
    repeat (3) @(posedge clk);
    #1 pause_ctrl_sink_data = 2'b00;
    wait_idle();
    chk("xon_follow_gap", 32'(last_gap), 32'(BACK2BACK_GAP));
    chk("pause_after_follow_xon", 32'(pause_active), 32'd0);

    // Reset in the middle of a frame, then a clean restart.
    exp_q.push_back(1'b1);
    @(posedge clk);
    #1 pause_ctrl_sink_data = 2'b10;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (b >= 30 && in_frame) break;
    end
    chk("reached_beat_30", 32'(b >= 30 && in_frame), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("valid_drop_on_reset", 32'(src_valid), 32'd0);
    chk("eop_on_reset", 32'(src_endofpacket | frame_sent), 32'd0);
    exp_q.push_back(1'b1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 pause_ctrl_sink_data = 2'b00;
    wait_idle();
    chk("pause_after_restart", 32'(pause_active), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
